// File: rtl/gear_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gear_pkg
// Description : Shared types, constants and zone helpers for the gear shift
//               sequencing controller (states, rpm bands, drive modes).
// Revision    : 1.0 - initial release
// ============================================================================
package gear_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_CRANK    = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_RUN      = 3'd3,
    ST_SHUTDOWN = 3'd4
  } state_t;

  // Which shift condition the hold counter is currently timing.
  typedef enum logic [1:0] {
    ZONE_NONE = 2'd0,
    ZONE_UP   = 2'd1,
    ZONE_DOWN = 2'd2
  } zone_t;

  localparam logic [1:0] RPM_IDLE = 2'd0;
  localparam logic [1:0] RPM_LOW  = 2'd1;
  localparam logic [1:0] RPM_MID  = 2'd2;
  localparam logic [1:0] RPM_HIGH = 2'd3;

  localparam logic [1:0] MODE_ECO    = 2'b00;
  localparam logic [1:0] MODE_NORMAL = 2'b01;
  localparam logic [1:0] MODE_SPORT  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  // Eco shifts up early (mid band); every other mode waits for high band.
  function automatic logic up_zone(input logic [1:0] m, input logic [1:0] r);
    logic v;
    v = 1'b0;
    case (m)
      MODE_ECO:                         v = (r >= RPM_MID);
      MODE_NORMAL, MODE_SPORT, MODE_RSVD: v = (r == RPM_HIGH);
      default:                          v = (r == RPM_HIGH);
    endcase
    return v;
  endfunction

  // Sport shifts down early (low band); other modes wait for idle.
  function automatic logic down_zone(input logic [1:0] m, input logic [1:0] r);
    logic v;
    v = 1'b0;
    case (m)
      MODE_SPORT:                       v = (r <= RPM_LOW);
      MODE_ECO, MODE_NORMAL, MODE_RSVD: v = (r == RPM_IDLE);
      default:                          v = (r == RPM_IDLE);
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gear_shift_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : gear_shift_ctrl_if
// Description : Signal bundle between the driver/transmission side and the
//               gear shift sequencing controller.
//   start_req  : engine start request (level or pulse)
//   stop_req   : engine stop request (level or pulse)
//   R[1:0]     : rpm band from the revolution FSM
//   M[1:0]     : drive mode from the mode-change FSM
//   A          : engine-on command
//   clutch     : clutch open
//   gear[2:0]  : engaged gear, 0 = neutral
//   shift_done : one-cycle pulse when a shift completes
//   fault      : sticky over-rev fault
//   master modport = environment side, slave modport = controller side.
// Revision    : 1.0 - initial release
// ============================================================================
interface gear_shift_ctrl_if;
  logic       start_req;
  logic       stop_req;
  logic [1:0] R;
  logic [1:0] M;
  logic       A;
  logic       clutch;
  logic [2:0] gear;
  logic       shift_done;
  logic       fault;

  modport master (
    output start_req, stop_req, R, M,
    input  A, clutch, gear, shift_done, fault
  );

  modport slave (
    input  start_req, stop_req, R, M,
    output A, clutch, gear, shift_done, fault
  );
endinterface
`default_nettype wire

// File: rtl/shift_timer.sv
`default_nettype none
// ============================================================================
// Module      : shift_timer
// Description : Loadable down-counter shared by the crank, shift dwell and
//               shutdown dwell phases. o_done is high during the last cycle
//               of a loaded interval, so a load of N yields N cycles.
//   clk, reset : clock, synchronous active-high reset
//   i_load     : load i_val (takes priority over counting)
//   i_val      : interval length in cycles
//   o_done     : last cycle of the interval
// Revision    : 1.0 - initial release
// ============================================================================
module shift_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == W'(1));

endmodule
`default_nettype wire

// File: rtl/gear_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gear_shift_ctrl
// Description : Sequencing controller for the transmission FSM pair. Owns the
//               engine-on command, cranks, engages first gear, then shifts up
//               and down with hold-time hysteresis on the rpm band.
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   bus        : gear_shift_ctrl_if.slave (requests, R, M in; A, clutch,
//                gear, shift_done, fault out; all outputs registered)
// Build option: define OVERREV_GUARD_EN to enable the over-rev monitor in
//               top gear (sticky fault + forced shutdown); otherwise fault
//               stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module gear_shift_ctrl
  import gear_pkg::*;
#(
  parameter int NGEARS    = 5,
  parameter int CRANK_CYC = 8,
  parameter int DWELL_CYC = 4,
  parameter int HOLD_CYC  = 3
) (
  input  logic             clk,
  input  logic             reset,
  gear_shift_ctrl_if.slave bus
);

  localparam int         TMR_MAX  = (CRANK_CYC > DWELL_CYC) ? CRANK_CYC : DWELL_CYC;
  localparam int         TW       = $clog2(TMR_MAX + 1);
  localparam int         HW       = $clog2(HOLD_CYC + 1);
  localparam logic [2:0] TOP_GEAR = 3'(NGEARS);

  state_t          r_state, w_state_nxt;
  logic            r_a, r_clutch, r_done, r_fault;
  logic [2:0]      r_gear, r_target;
  logic [HW-1:0]   r_hold;
  zone_t           r_zone;

  logic            w_tmr_load, w_tmr_done;
  logic [TW-1:0]   w_tmr_val;
  logic [2:0]      w_target_nxt;
  zone_t           w_zone;
  logic [HW-1:0]   w_hold_inc;
  logic            w_hold_hit;
  logic            w_ovr_trip;
  logic            w_a_nxt, w_clutch_nxt, w_done_nxt, w_fault_nxt;
  logic [2:0]      w_gear_nxt;

  shift_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_done (w_tmr_done)
  );

  // Shift zone, with the gear limits folded in so that top gear never sees
  // an up-zone and first gear never sees a down-zone.
  always_comb begin
    w_zone = ZONE_NONE;
    if (r_state == ST_RUN) begin
      if ((r_gear < TOP_GEAR) && up_zone(bus.M, bus.R)) begin
        w_zone = ZONE_UP;
      end else if ((r_gear > 3'd1) && down_zone(bus.M, bus.R)) begin
        w_zone = ZONE_DOWN;
      end
    end
  end

  // A fresh zone counts as its first persistent cycle.
  always_comb begin
    w_hold_inc = '0;
    if (w_zone != ZONE_NONE) begin
      w_hold_inc = (w_zone == r_zone) ? (r_hold + HW'(1)) : HW'(1);
    end
  end

  assign w_hold_hit = (w_zone != ZONE_NONE) && (w_hold_inc == HW'(HOLD_CYC));

  always_ff @(posedge clk) begin
    if (reset || w_hold_hit) begin
      r_hold <= '0;
      r_zone <= ZONE_NONE;
    end else begin
      r_hold <= w_hold_inc;
      r_zone <= w_zone;
    end
  end

`ifdef OVERREV_GUARD_EN
  localparam int OVR_CYC = 4 * HOLD_CYC;
  localparam int OW      = $clog2(OVR_CYC + 1);

  logic [OW-1:0] r_ovr, w_ovr_inc;
  logic          w_ovr_cond;

  assign w_ovr_cond = (r_state == ST_RUN) && (r_gear == TOP_GEAR) && (bus.R == RPM_HIGH);
  assign w_ovr_inc  = w_ovr_cond ? (r_ovr + OW'(1)) : '0;
  assign w_ovr_trip = w_ovr_cond && (w_ovr_inc == OW'(OVR_CYC));

  always_ff @(posedge clk) begin
    if (reset || w_ovr_trip) begin
      r_ovr <= '0;
    end else begin
      r_ovr <= w_ovr_inc;
    end
  end
`else
  assign w_ovr_trip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. stop_req outranks every other transition outside OFF;
  // a stop already being serviced in SHUTDOWN does not restart the dwell.
  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_target_nxt = r_target;
    case (r_state)
      ST_OFF: begin
        if (bus.start_req && !bus.stop_req && !r_fault) begin
          w_state_nxt = ST_CRANK;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(CRANK_CYC);
        end
      end
      ST_CRANK: begin
        if (bus.stop_req) begin
          w_state_nxt = ST_SHUTDOWN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(DWELL_CYC);
        end else if (w_tmr_done) begin
          w_state_nxt  = ST_SHIFT;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(DWELL_CYC);
          w_target_nxt = 3'd1;
        end
      end
      ST_SHIFT: begin
        if (bus.stop_req) begin
          w_state_nxt = ST_SHUTDOWN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(DWELL_CYC);
        end else if (w_tmr_done) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.stop_req || w_ovr_trip) begin
          w_state_nxt = ST_SHUTDOWN;
          w_tmr_load  = 1'b1;
          w_tmr_val   = TW'(DWELL_CYC);
        end else if (w_hold_hit) begin
          w_state_nxt  = ST_SHIFT;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TW'(DWELL_CYC);
          w_target_nxt = (w_zone == ZONE_UP) ? (r_gear + 3'd1) : (r_gear - 3'd1);
        end
      end
      ST_SHUTDOWN: begin
        if (w_tmr_done) begin
          w_state_nxt = ST_OFF;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
  end

  // Output logic: next values of the registered outputs, keyed on the
  // transition being taken this cycle.
  always_comb begin
    w_a_nxt      = r_a;
    w_clutch_nxt = r_clutch;
    w_gear_nxt   = r_gear;
    w_done_nxt   = 1'b0;
    w_fault_nxt  = r_fault | w_ovr_trip;
    if ((r_state == ST_OFF) && (w_state_nxt == ST_CRANK)) begin
      w_a_nxt = 1'b1;
    end
    if ((w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_SHUTDOWN)) begin
      w_clutch_nxt = 1'b1;
    end
    if ((r_state == ST_SHIFT) && (w_state_nxt == ST_RUN)) begin
      w_gear_nxt   = r_target;
      w_clutch_nxt = 1'b0;
      w_done_nxt   = 1'b1;
    end
    if ((r_state == ST_SHUTDOWN) && (w_state_nxt == ST_OFF)) begin
      w_gear_nxt   = 3'd0;
      w_clutch_nxt = 1'b0;
      w_a_nxt      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a      <= 1'b0;
      r_clutch <= 1'b0;
      r_gear   <= 3'd0;
      r_done   <= 1'b0;
      r_fault  <= 1'b0;
      r_target <= 3'd0;
    end else begin
      r_a      <= w_a_nxt;
      r_clutch <= w_clutch_nxt;
      r_gear   <= w_gear_nxt;
      r_done   <= w_done_nxt;
      r_fault  <= w_fault_nxt;
      r_target <= w_target_nxt;
    end
  end

  assign bus.A          = r_a;
  assign bus.clutch     = r_clutch;
  assign bus.gear       = r_gear;
  assign bus.shift_done = r_done;
  assign bus.fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_gear_shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_gear_shift_ctrl
// Description : Directed, table-driven bench for gear_shift_ctrl with
//               hand-written sequences for abort, over-rev and reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gear_shift_ctrl;
  import gear_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gear_shift_ctrl_if bus();

  gear_shift_ctrl #(
    .NGEARS(5), .CRANK_CYC(8), .DWELL_CYC(4), .HOLD_CYC(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         n;
    logic       st;
    logic       sp;
    logic [1:0] r;
    logic [1:0] m;
    logic       a;
    logic       cl;
    logic [2:0] g;
    logic       d;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input int n, input logic st, input logic sp,
                             input logic [1:0] r, input logic [1:0] m,
                             input logic a, input logic cl,
                             input logic [2:0] g, input logic d);
    vec_t x;
    x.n = n; x.st = st; x.sp = sp; x.r = r; x.m = m;
    x.a = a; x.cl = cl; x.g = g; x.d = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, then compare all outputs 1 time unit later.
  task automatic step(input string tag, input logic st, input logic sp,
                      input logic [1:0] r, input logic [1:0] m,
                      input logic a, input logic cl, input logic [2:0] g,
                      input logic d, input logic f);
    bus.start_req = st;
    bus.stop_req  = sp;
    bus.R         = r;
    bus.M         = m;
    @(posedge clk);
    #1;
    chk({tag, ".A"},          {2'b00, bus.A},          {2'b00, a});
    chk({tag, ".clutch"},     {2'b00, bus.clutch},     {2'b00, cl});
    chk({tag, ".gear"},       bus.gear,                g);
    chk({tag, ".shift_done"}, {2'b00, bus.shift_done}, {2'b00, d});
    chk({tag, ".fault"},      {2'b00, bus.fault},      {2'b00, f});
  endtask

  task automatic do_reset(input string tag);
    reset         = 1'b1;
    bus.start_req = 1'b0;
    bus.stop_req  = 1'b0;
    bus.R         = RPM_IDLE;
    bus.M         = MODE_NORMAL;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".A"},          {2'b00, bus.A},          3'd0);
    chk({tag, ".clutch"},     {2'b00, bus.clutch},     3'd0);
    chk({tag, ".gear"},       bus.gear,                3'd0);
    chk({tag, ".shift_done"}, {2'b00, bus.shift_done}, 3'd0);
    chk({tag, ".fault"},      {2'b00, bus.fault},      3'd0);
    reset = 1'b0;
  endtask

  // Start pulse, 8 crank cycles, 4 dwell cycles, first gear engaged.
  task automatic boot(input string tag);
    step({tag, ".start"}, 1, 0, 0, MODE_NORMAL, 1, 0, 0, 0, 0);
    repeat (7) step({tag, ".crank"}, 0, 0, 0, MODE_NORMAL, 1, 0, 0, 0, 0);
    repeat (4) step({tag, ".dwell"}, 0, 0, 0, MODE_NORMAL, 1, 1, 0, 0, 0);
    step({tag, ".g1"}, 0, 0, 0, MODE_NORMAL, 1, 0, 1, 1, 0);
  endtask

  // Normal-mode upshift from gear g: 3 cycles of R=3, then 4 dwell cycles.
  task automatic upshift(input string tag, input logic [2:0] g);
    repeat (2) step({tag, ".hold"}, 0, 0, 3, MODE_NORMAL, 1, 0, g, 0, 0);
    step({tag, ".go"}, 0, 0, 3, MODE_NORMAL, 1, 1, g, 0, 0);
    repeat (3) step({tag, ".dwell"}, 0, 0, 1, MODE_NORMAL, 1, 1, g, 0, 0);
    step({tag, ".done"}, 0, 0, 1, MODE_NORMAL, 1, 0, g + 3'd1, 1, 0);
  endtask

  initial begin
    //        n st sp R  M            A  cl g  d
    tbl.push_back(v( 1, 1, 0, 0, MODE_NORMAL, 1, 0, 0, 0));  // start pulse
    tbl.push_back(v( 7, 0, 0, 0, MODE_NORMAL, 1, 0, 0, 0));  // crank
    tbl.push_back(v( 4, 0, 0, 0, MODE_NORMAL, 1, 1, 0, 0));  // first dwell
    tbl.push_back(v( 1, 0, 0, 0, MODE_NORMAL, 1, 0, 1, 1));  // gear 1
    tbl.push_back(v( 2, 0, 0, 0, MODE_NORMAL, 1, 0, 1, 0));
    tbl.push_back(v( 2, 0, 0, 3, MODE_NORMAL, 1, 0, 1, 0));  // R=3 only twice
    tbl.push_back(v( 5, 0, 0, 2, MODE_NORMAL, 1, 0, 1, 0));  // broken: no shift
    tbl.push_back(v( 2, 0, 0, 3, MODE_NORMAL, 1, 0, 1, 0));  // normal 1->2
    tbl.push_back(v( 1, 0, 0, 3, MODE_NORMAL, 1, 1, 1, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_NORMAL, 1, 1, 1, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_NORMAL, 1, 0, 2, 1));
    tbl.push_back(v( 2, 0, 0, 2, MODE_ECO,    1, 0, 2, 0));  // eco 2->3 on R=2
    tbl.push_back(v( 1, 0, 0, 2, MODE_ECO,    1, 1, 2, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_ECO,    1, 1, 2, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_ECO,    1, 0, 3, 1));
    tbl.push_back(v( 2, 0, 0, 0, MODE_ECO,    1, 0, 3, 0));  // eco 3->2 on R=0
    tbl.push_back(v( 1, 0, 0, 0, MODE_ECO,    1, 1, 3, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_ECO,    1, 1, 3, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_ECO,    1, 0, 2, 1));
    tbl.push_back(v( 2, 0, 0, 0, MODE_ECO,    1, 0, 2, 0));  // eco 2->1
    tbl.push_back(v( 1, 0, 0, 0, MODE_ECO,    1, 1, 2, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_ECO,    1, 1, 2, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_ECO,    1, 0, 1, 1));
    tbl.push_back(v(10, 0, 0, 0, MODE_ECO,    1, 0, 1, 0));  // gear 1 floor
    tbl.push_back(v( 2, 0, 0, 3, MODE_RSVD,   1, 0, 1, 0));  // reserved = normal
    tbl.push_back(v( 1, 0, 0, 3, MODE_RSVD,   1, 1, 1, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_RSVD,   1, 1, 1, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_RSVD,   1, 0, 2, 1));
    tbl.push_back(v( 2, 0, 0, 3, MODE_SPORT,  1, 0, 2, 0));  // sport 2->3
    tbl.push_back(v( 1, 0, 0, 3, MODE_SPORT,  1, 1, 2, 0));
    tbl.push_back(v( 3, 0, 0, 2, MODE_SPORT,  1, 1, 2, 0));
    tbl.push_back(v( 1, 0, 0, 2, MODE_SPORT,  1, 0, 3, 1));
    tbl.push_back(v( 2, 0, 0, 1, MODE_SPORT,  1, 0, 3, 0));  // sport 3->2 on R=1
    tbl.push_back(v( 1, 0, 0, 1, MODE_SPORT,  1, 1, 3, 0));
    tbl.push_back(v( 3, 0, 0, 2, MODE_SPORT,  1, 1, 3, 0));
    tbl.push_back(v( 1, 0, 0, 2, MODE_SPORT,  1, 0, 2, 1));
    tbl.push_back(v( 2, 0, 0, 3, MODE_NORMAL, 1, 0, 2, 0));  // 2->3
    tbl.push_back(v( 1, 0, 0, 3, MODE_NORMAL, 1, 1, 2, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_NORMAL, 1, 1, 2, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_NORMAL, 1, 0, 3, 1));
    tbl.push_back(v( 2, 0, 0, 3, MODE_NORMAL, 1, 0, 3, 0));  // 3->4
    tbl.push_back(v( 1, 0, 0, 3, MODE_NORMAL, 1, 1, 3, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_NORMAL, 1, 1, 3, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_NORMAL, 1, 0, 4, 1));
    tbl.push_back(v( 2, 0, 0, 3, MODE_NORMAL, 1, 0, 4, 0));  // 4->5
    tbl.push_back(v( 1, 0, 0, 3, MODE_NORMAL, 1, 1, 4, 0));
    tbl.push_back(v( 3, 0, 0, 1, MODE_NORMAL, 1, 1, 4, 0));
    tbl.push_back(v( 1, 0, 0, 1, MODE_NORMAL, 1, 0, 5, 1));
    tbl.push_back(v(10, 0, 0, 3, MODE_NORMAL, 1, 0, 5, 0));  // top gear ceiling

    do_reset("rst0");

    for (int i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++) begin
        step($sformatf("row%0d", i), tbl[i].st, tbl[i].sp, tbl[i].r, tbl[i].m,
             tbl[i].a, tbl[i].cl, tbl[i].g, tbl[i].d, 1'b0);
      end
    end

`ifdef OVERREV_GUARD_EN
    // 11th and 12th consecutive R=3 cycles in gear 5: trip on the 12th.
    step("ovr11", 0, 0, 3, MODE_NORMAL, 1, 0, 5, 0, 0);
    step("ovr12", 0, 0, 3, MODE_NORMAL, 1, 1, 5, 0, 1);
    repeat (3) step("ovr_sd", 0, 0, 0, MODE_NORMAL, 1, 1, 5, 0, 1);
    step("ovr_off", 0, 0, 0, MODE_NORMAL, 0, 0, 0, 0, 1);
    step("ovr_start", 1, 0, 0, MODE_NORMAL, 0, 0, 0, 0, 1);
    repeat (3) step("ovr_ign", 0, 0, 0, MODE_NORMAL, 0, 0, 0, 0, 1);
`else
    repeat (2) step("top_hold", 0, 0, 3, MODE_NORMAL, 1, 0, 5, 0, 0);
    // Stop from RUN: 4 dwell cycles, then neutral and engine off.
    step("run_stop", 0, 1, 1, MODE_NORMAL, 1, 1, 5, 0, 0);
    repeat (3) step("run_sd", 0, 0, 1, MODE_NORMAL, 1, 1, 5, 0, 0);
    step("run_off", 0, 0, 1, MODE_NORMAL, 0, 0, 0, 0, 0);
`endif

    // Abort a 2->3 shift on its second dwell cycle, with start_req also high.
    do_reset("rst1");
    boot("b1");
    upshift("u12", 3'd2 - 3'd1);
    repeat (2) step("ab.hold", 0, 0, 3, MODE_NORMAL, 1, 0, 2, 0, 0);
    step("ab.sh1", 0, 0, 3, MODE_NORMAL, 1, 1, 2, 0, 0);
    step("ab.sh2", 0, 0, 1, MODE_NORMAL, 1, 1, 2, 0, 0);
    step("ab.stop", 1, 1, 1, MODE_NORMAL, 1, 1, 2, 0, 0);
    repeat (3) step("ab.sd", 0, 0, 1, MODE_NORMAL, 1, 1, 2, 0, 0);
    step("ab.off", 0, 0, 1, MODE_NORMAL, 0, 0, 0, 0, 0);
    step("ab.idle", 0, 0, 1, MODE_NORMAL, 0, 0, 0, 0, 0);

    // start and stop together in OFF: stay OFF.
    repeat (2) step("both", 1, 1, 0, MODE_NORMAL, 0, 0, 0, 0, 0);

    // Reset in the middle of the first dwell.
    step("mr.start", 1, 0, 0, MODE_NORMAL, 1, 0, 0, 0, 0);
    repeat (7) step("mr.crank", 0, 0, 0, MODE_NORMAL, 1, 0, 0, 0, 0);
    repeat (2) step("mr.dwell", 0, 0, 0, MODE_NORMAL, 1, 1, 0, 0, 0);
    reset = 1'b1;
    step("mr.rst", 0, 0, 0, MODE_NORMAL, 0, 0, 0, 0, 0);
    reset = 1'b0;
    step("mr.idle", 0, 0, 0, MODE_NORMAL, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
